// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sequencer sharing one external WIDTH-bit adder among NUM_REQ requesters.
// Optional build macro ADD_ARB_SUB_EN adds a per-requester subtract select (A - B).
module add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    input  logic [NUM_REQ-1:0]       cin,
`ifdef ADD_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]       sub,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic                     cout,
    output logic [ID_W-1:0]          result_id,
    output logic [WIDTH-1:0]         add_rA,
    output logic [WIDTH-1:0]         add_rB,
    output logic                     add_cIn,
    input  logic [WIDTH-1:0]         add_S,
    input  logic                     add_cOut
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t               state;
    state_t               stateNext;
    logic [ID_W-1:0]      rrPtr;
    logic [ID_W-1:0]      rrPtrNext;
    logic [ID_W-1:0]      candIdx;
    logic [ID_W-1:0]      selIdx;
    logic                 anyReq;
    logic                 grantFire;
    logic [NUM_REQ-1:0]   gntOneHot;
    logic [WIDTH-1:0]     selA;
    logic [WIDTH-1:0]     selB;
    logic                 selCin;

    logic [WIDTH-1:0]     rA_p1;
    logic [WIDTH-1:0]     rB_p1;
    logic                 cIn_p1;
    logic [ID_W-1:0]      id_p1;

    always_comb begin
        candIdx   = '0;
        selIdx    = '0;
        anyReq    = 1'b0;
        stateNext = state;

        // First set request at or above rrPtr, wrapping at NUM_REQ.
        for (int k = 0; k < NUM_REQ; k++) begin
            candIdx = ID_W'((int'(rrPtr) + k) % NUM_REQ);
            if (!anyReq && req[candIdx]) begin
                anyReq = 1'b1;
                selIdx = candIdx;
            end
        end

        grantFire = (state == IDLE) && anyReq;
        rrPtrNext = ID_W'((int'(selIdx) + 1) % NUM_REQ);
        gntOneHot = NUM_REQ'(1) << selIdx;

        selA   = op_a[int'(selIdx)*WIDTH +: WIDTH];
        selB   = op_b[int'(selIdx)*WIDTH +: WIDTH];
        selCin = cin[selIdx];
`ifdef ADD_ARB_SUB_EN
        if (sub[selIdx]) begin
            selB   = ~selB;
            selCin = 1'b1;
        end
`endif

        case (state)
            IDLE:    if (anyReq) stateNext = EXEC;
            EXEC:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rrPtr     <= '0;
            gnt       <= '0;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            result_id <= '0;
            rA_p1     <= '0;
            rB_p1     <= '0;
            cIn_p1    <= 1'b0;
            id_p1     <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            // Stage 1: capture the granted requester's operands for the EXEC cycle.
            if (grantFire) begin
                gnt    <= gntOneHot;
                rA_p1  <= selA;
                rB_p1  <= selB;
                cIn_p1 <= selCin;
                id_p1  <= selIdx;
                rrPtr  <= rrPtrNext;
            end
            // Stage 2: register the adder output; held until the next done.
            if (state == EXEC) begin
                result    <= add_S;
                cout      <= add_cOut;
                result_id <= id_p1;
                done      <= 1'b1;
            end
        end
    end

    assign add_rA  = rA_p1;
    assign add_rB  = rB_p1;
    assign add_cIn = cIn_p1;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: scoreboard bench for add_arbiter with directed cases and randomized request traffic.
// Stands in for the shared adder; honours ADD_ARB_SUB_EN when defined.
module tb_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = 2;

    typedef struct {
        int               c;
        int               id;
        logic [WIDTH-1:0] s;
        logic             co;
    } exp_t;

    logic                     clock = 1'b0;
    logic                     resetn = 1'b0;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ*WIDTH-1:0] op_a = '0;
    logic [NUM_REQ*WIDTH-1:0] op_b = '0;
    logic [NUM_REQ-1:0]       cin = '0;
`ifdef ADD_ARB_SUB_EN
    logic [NUM_REQ-1:0]       sub = '0;
`endif
    logic [NUM_REQ-1:0]       gnt;
    logic                     done;
    logic [WIDTH-1:0]         result;
    logic                     cout;
    logic [ID_W-1:0]          result_id;
    logic [WIDTH-1:0]         add_rA;
    logic [WIDTH-1:0]         add_rB;
    logic                     add_cIn;
    logic [WIDTH-1:0]         add_S;
    logic                     add_cOut;

    // Requester-side view of operands.
    logic [WIDTH-1:0] a [NUM_REQ];
    logic [WIDTH-1:0] b [NUM_REQ];
    logic             ci[NUM_REQ];
    logic             sb[NUM_REQ];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mPtr = 0;
    bit   mBusy = 1'b0;
    exp_t gntQ[$];
    exp_t resQ[$];

    add_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clock(clock), .resetn(resetn), .req(req), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef ADD_ARB_SUB_EN
        .sub(sub),
`endif
        .gnt(gnt), .done(done), .result(result), .cout(cout), .result_id(result_id),
        .add_rA(add_rA), .add_rB(add_rB), .add_cIn(add_cIn), .add_S(add_S), .add_cOut(add_cOut)
    );

    assign {add_cOut, add_S} = {1'b0, add_rA} + {1'b0, add_rB} + {{WIDTH{1'b0}}, add_cIn};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyInputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i*WIDTH +: WIDTH] = a[i];
            op_b[i*WIDTH +: WIDTH] = b[i];
            cin[i] = ci[i];
`ifdef ADD_ARB_SUB_EN
            sub[i] = sb[i];
`endif
        end
    endtask

    function automatic logic [WIDTH-1:0] randWord();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic randOps(input int i);
        a[i]  = randWord();
        b[i]  = randWord();
        ci[i] = 1'($urandom_range(0, 1));
`ifdef ADD_ARB_SUB_EN
        sb[i] = 1'($urandom_range(0, 1));
`else
        sb[i] = 1'b0;
`endif
    endtask

    // Advance one clock; model what the arbiter should have decided at that edge.
    task automatic tick(output int pick);
        logic               rstS;
        logic [NUM_REQ-1:0] reqS;
        logic [WIDTH:0]     sum;
        exp_t               e;
        int                 idx;
        rstS = resetn;
        reqS = req;
        pick = -1;
        @(posedge clock);
        #1;
        if (!rstS) begin
            mPtr  = 0;
            mBusy = 1'b0;
            gntQ.delete();
            resQ.delete();
        end else if (mBusy) begin
            mBusy = 1'b0;
        end else if (reqS != '0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (mPtr + k) % NUM_REQ;
                if (pick < 0 && reqS[idx]) pick = idx;
            end
            if (sb[pick]) begin
                sum[WIDTH-1:0] = a[pick] - b[pick];
                sum[WIDTH]     = (a[pick] >= b[pick]);
            end else begin
                sum = {1'b0, a[pick]} + {1'b0, b[pick]} + {{WIDTH{1'b0}}, ci[pick]};
            end
            e.c = cyc; e.id = pick; e.s = '0; e.co = 1'b0;
            gntQ.push_back(e);
            e.c = cyc + 1; e.s = sum[WIDTH-1:0]; e.co = sum[WIDTH];
            resQ.push_back(e);
            mBusy = 1'b1;
            mPtr  = (pick + 1) % NUM_REQ;
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents gnt or done.
    always @(negedge clock) begin
        exp_t e;
        while (gntQ.size() > 0 && gntQ[0].c < cyc) begin
            e = gntQ.pop_front();
            check("gnt missing", 64'(cyc), 64'(e.c));
        end
        while (resQ.size() > 0 && resQ[0].c < cyc) begin
            e = resQ.pop_front();
            check("done missing", 64'(cyc), 64'(e.c));
        end
        if (gnt != '0) begin
            if (gntQ.size() == 0) begin
                check("gnt unexpected", 64'(gnt), 64'(0));
            end else begin
                e = gntQ.pop_front();
                check("gnt onehot", 64'(gnt), 64'(1) << e.id);
                check("gnt cycle", 64'(cyc), 64'(e.c));
            end
        end
        if (done) begin
            if (resQ.size() == 0) begin
                check("done unexpected", 64'(done), 64'(0));
            end else begin
                e = resQ.pop_front();
                check("sb result", 64'(result), 64'(e.s));
                check("sb cout", 64'(cout), 64'(e.co));
                check("sb result_id", 64'(result_id), 64'(e.id));
                check("done cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    task automatic runOp(input int idx, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv, input logic [WIDTH-1:0] expS, input logic expC);
        int p;
        a[idx] = av; b[idx] = bv; ci[idx] = cv; sb[idx] = sv;
        req = NUM_REQ'(1) << idx;
        applyInputs();
        tick(p);
        check("direct gnt", 64'(gnt), 64'(1) << idx);
        check("direct add_rA", 64'(add_rA), 64'(av));
        randOps(idx);
        req = '0;
        applyInputs();
        tick(p);
        check("direct done", 64'(done), 64'(1));
        check("direct result", 64'(result), 64'(expS));
        check("direct cout", 64'(cout), 64'(expC));
        check("direct result_id", 64'(result_id), 64'(idx));
    endtask

    initial begin
        int p;
        int gi;
        int order[$];
        int gcyc[$];

        for (int i = 0; i < NUM_REQ; i++) begin
            randOps(i);
            sb[i] = 1'b0;
        end
        applyInputs();

        resetn = 1'b0;
        req = '1;
        repeat (2) begin
            tick(p);
            check("reset gnt", 64'(gnt), 64'(0));
            check("reset done", 64'(done), 64'(0));
            check("reset result", 64'(result), 64'(0));
            check("reset cout", 64'(cout), 64'(0));
            check("reset result_id", 64'(result_id), 64'(0));
            check("reset add_rA", 64'(add_rA), 64'(0));
        end

        resetn = 1'b1;
        tick(p);
        check("release gnt", 64'(gnt), 64'(4'b0001));
        req = '0;
        tick(p);

        runOp(2, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
        runOp(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
`ifdef ADD_ARB_SUB_EN
        runOp(1, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
`endif

        // Fairness from a fresh pointer with every requester asking.
        resetn = 1'b0;
        tick(p);
        resetn = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            randOps(i);
            sb[i] = 1'b0;
        end
        applyInputs();
        req = '1;
        repeat (16) begin
            tick(p);
            if (gnt != '0) begin
                gi = -1;
                for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gi = i;
                order.push_back(gi);
                gcyc.push_back(cyc);
            end
        end
        check("fair count", 64'(order.size()), 64'(8));
        for (int i = 0; i < order.size(); i++) check("fair order", 64'(order[i]), 64'(i % NUM_REQ));
        for (int i = 1; i < gcyc.size(); i++) check("fair spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(2));

        // Reset lands on the edge that would have completed the operation.
        req = 4'b0010;
        tick(p);
        check("midop gnt", 64'(gnt), 64'(4'b0010));
        req = '0;
        resetn = 1'b0;
        tick(p);
        check("midop done", 64'(done), 64'(0));
        check("midop result", 64'(result), 64'(0));
        check("midop cout", 64'(cout), 64'(0));
        resetn = 1'b1;
        tick(p);
        check("midop done after", 64'(done), 64'(0));
        check("midop gnt after", 64'(gnt), 64'(0));

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            tick(p);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == p) begin
                    randOps(i);
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    randOps(i);
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
            applyInputs();
        end

        req = '0;
        repeat (4) tick(p);
        check("scoreboard drained", 64'(gntQ.size() + resQ.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
